// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: ID/EXE/MEM status in, stage controls out.
// master = pipeline datapath, slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_src1;
  logic [4:0]       id_src2;
  logic             id_two_src;
  logic             exe_wb_en;
  logic             exe_mem_read;
  logic [4:0]       exe_dest;
  logic             mem_wb_en;
  logic [4:0]       mem_dest;
  logic             br_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_freeze;
  logic             if2id_freeze;
  logic             if2id_flush;
  logic             id2exe_bubble;
  logic             pipe_freeze;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_src1, id_src2, id_two_src, exe_wb_en, exe_mem_read, exe_dest,
           mem_wb_en, mem_dest, br_taken, mem_req, mem_ready,
    input  pc_freeze, if2id_freeze, if2id_flush, id2exe_bubble, pipe_freeze,
           mem_err, stall_cnt
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, exe_wb_en, exe_mem_read, exe_dest,
           mem_wb_en, mem_dest, br_taken, mem_req, mem_ready,
    output pc_freeze, if2id_freeze, if2id_flush, id2exe_bubble, pipe_freeze,
           mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Freeze/flush/bubble control for the 5-stage pipe: RAW hazards, taken branches, memory stalls.
// Optional macro PIPE_FORWARD_EN: forwarding present, only load-use against EXE stalls.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  // state | meaning
  // RUN   | normal flow; a memory access not ready this cycle moves to WAIT
  // WAIT  | whole pipe frozen until mem_ready, bounded by TIMEOUT
  // ERR   | memory timeout, everything frozen until rst
  typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, ERR = 2'd2} state_t;

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  state_t           state;
  logic [WC_W-1:0]  wait_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_err_q;
  logic             src1_hit;
  logic             src2_hit;
  logic             hazard;
  logic             mem_stall;

  function automatic logic dep_hit(input logic [4:0] src, input logic [4:0] dest, input logic en);
    return en && (dest != 5'd0) && (src == dest);
  endfunction

`ifdef PIPE_FORWARD_EN
  logic unused_mem_fwd;
  assign unused_mem_fwd = ^{bus.mem_wb_en, bus.mem_dest};
`else
  logic unused_exe_rd;
  assign unused_exe_rd = bus.exe_mem_read;
`endif

  always_comb begin
`ifdef PIPE_FORWARD_EN
    src1_hit = dep_hit(bus.id_src1, bus.exe_dest, bus.exe_wb_en & bus.exe_mem_read);
    src2_hit = dep_hit(bus.id_src2, bus.exe_dest, bus.exe_wb_en & bus.exe_mem_read);
`else
    src1_hit = dep_hit(bus.id_src1, bus.exe_dest, bus.exe_wb_en) |
               dep_hit(bus.id_src1, bus.mem_dest, bus.mem_wb_en);
    src2_hit = dep_hit(bus.id_src2, bus.exe_dest, bus.exe_wb_en) |
               dep_hit(bus.id_src2, bus.mem_dest, bus.mem_wb_en);
`endif
    hazard    = src1_hit | (bus.id_two_src & src2_hit);
    mem_stall = ((state == RUN) & bus.mem_req & ~bus.mem_ready) |
                ((state == WAIT) & ~bus.mem_ready) |
                (state == ERR);
  end

  // Zero-latency controls: stage registers sample these on the same edge.
  always_comb begin
    bus.pipe_freeze   = 1'b0;
    bus.pc_freeze     = 1'b0;
    bus.if2id_freeze  = 1'b0;
    bus.if2id_flush   = 1'b0;
    bus.id2exe_bubble = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        bus.pipe_freeze  = 1'b1;
        bus.pc_freeze    = 1'b1;
        bus.if2id_freeze = 1'b1;
      end else if (bus.br_taken) begin
        bus.if2id_flush   = 1'b1;
        bus.id2exe_bubble = 1'b1;
      end else if (hazard) begin
        bus.pc_freeze     = 1'b1;
        bus.if2id_freeze  = 1'b1;
        bus.id2exe_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if (bus.pc_freeze && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      case (state)
        RUN: begin
          if (bus.mem_req && !bus.mem_ready) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (bus.mem_ready) begin
            state <= RUN;
          end else if (wait_cnt == WC_LAST) begin
            state     <= ERR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        ERR:     state <= ERR;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.mem_err   = mem_err_q;
  assign bus.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default instance plus a TIMEOUT=4 / CNT_W=4 instance
// sharing the same stimulus.
module tb_pipe_hazard_ctrl;
`ifdef PIPE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       id_two_src, exe_wb_en, exe_mem_read, mem_wb_en, br_taken, mem_req, mem_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_sc   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) ifa ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  ifb ();

  assign ifa.id_src1 = id_src1;           assign ifb.id_src1 = id_src1;
  assign ifa.id_src2 = id_src2;           assign ifb.id_src2 = id_src2;
  assign ifa.id_two_src = id_two_src;     assign ifb.id_two_src = id_two_src;
  assign ifa.exe_wb_en = exe_wb_en;       assign ifb.exe_wb_en = exe_wb_en;
  assign ifa.exe_mem_read = exe_mem_read; assign ifb.exe_mem_read = exe_mem_read;
  assign ifa.exe_dest = exe_dest;         assign ifb.exe_dest = exe_dest;
  assign ifa.mem_wb_en = mem_wb_en;       assign ifb.mem_wb_en = mem_wb_en;
  assign ifa.mem_dest = mem_dest;         assign ifb.mem_dest = mem_dest;
  assign ifa.br_taken = br_taken;         assign ifb.br_taken = br_taken;
  assign ifa.mem_req = mem_req;           assign ifb.mem_req = mem_req;
  assign ifa.mem_ready = mem_ready;       assign ifb.mem_ready = mem_ready;

  pipe_hazard_ctrl #(.TIMEOUT(255), .CNT_W(16)) u_dut   (.clk(clk), .rst(rst), .bus(ifa.slave));
  pipe_hazard_ctrl #(.TIMEOUT(4),   .CNT_W(4))  u_small (.clk(clk), .rst(rst), .bus(ifb.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_src1 = 5'd0; id_src2 = 5'd0; id_two_src = 1'b0;
    exe_wb_en = 1'b0; exe_mem_read = 1'b0; exe_dest = 5'd0;
    mem_wb_en = 1'b0; mem_dest = 5'd0;
    br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] dest);
    exe_wb_en = 1'b1; exe_mem_read = 1'b1; exe_dest = dest; id_src1 = 5'd5;
  endtask

  // Checks the default instance's combinational controls and tracks the expected stall count.
  task automatic expect_ctl(input string tag, input bit pc, input bit ifz, input bit fl,
                            input bit bub, input bit pf);
    check({tag, ".pc_freeze"},     32'(ifa.pc_freeze),     32'(pc));
    check({tag, ".if2id_freeze"},  32'(ifa.if2id_freeze),  32'(ifz));
    check({tag, ".if2id_flush"},   32'(ifa.if2id_flush),   32'(fl));
    check({tag, ".id2exe_bubble"}, 32'(ifa.id2exe_bubble), 32'(bub));
    check({tag, ".pipe_freeze"},   32'(ifa.pipe_freeze),   32'(pf));
    if (pc) exp_sc++;
  endtask

  initial begin
    // reset with aggressive stimulus: every control forced low
    idle();
    rst = 1'b1; mem_req = 1'b1; br_taken = 1'b1; load_use(5'd5);
    #2 expect_ctl("rst_a", 0, 0, 0, 0, 0);
    tick();
    expect_ctl("rst_b", 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0; idle();
    #1;
    check("rst.stall_cnt", 32'(ifa.stall_cnt), 32'd0);
    check("rst.mem_err",   32'(ifa.mem_err),   32'd0);
    check("rst.small_cnt", 32'(ifb.stall_cnt), 32'd0);
    expect_ctl("rst_idle", 0, 0, 0, 0, 0);
    exp_sc = 0;
    tick();

    // load-use stalls one cycle
    load_use(5'd5);
    #1 expect_ctl("ldu", 1, 1, 0, 1, 0);
    tick();
    idle();
    #1 expect_ctl("ldu_after", 0, 0, 0, 0, 0);
    check("ldu.stall_cnt", 32'(ifa.stall_cnt), 32'd1);
    tick();

    // dest r0 never stalls
    load_use(5'd0);
    #1 expect_ctl("r0", 0, 0, 0, 0, 0);
    tick();

    // MEM-stage match
    idle(); mem_wb_en = 1'b1; mem_dest = 5'd5; id_src1 = 5'd5;
    #1 expect_ctl("memdep", !FWD, !FWD, 0, !FWD, 0);
    tick();

    // EXE ALU result (not a load)
    idle(); exe_wb_en = 1'b1; exe_dest = 5'd5; id_src1 = 5'd5;
    #1 expect_ctl("alu", !FWD, !FWD, 0, !FWD, 0);
    tick();

    // src2 only compared when id_two_src
    idle(); exe_wb_en = 1'b1; exe_mem_read = 1'b1; exe_dest = 5'd7;
    id_src1 = 5'd3; id_src2 = 5'd7;
    #1 expect_ctl("src2_off", 0, 0, 0, 0, 0);
    tick();
    id_two_src = 1'b1;
    #1 expect_ctl("src2_on", 1, 1, 0, 1, 0);
    tick();

    // branch overrides hazard
    idle(); load_use(5'd5); br_taken = 1'b1;
    #1 expect_ctl("br_haz", 0, 0, 1, 1, 0);
    tick();
    idle();
    #1 check("br.stall_cnt", 32'(ifa.stall_cnt), 32'(exp_sc));

    // zero-stall memory access causes no state change
    mem_req = 1'b1; mem_ready = 1'b1;
    #1 expect_ctl("mem0", 0, 0, 0, 0, 0);
    tick();
    idle();
    #1 expect_ctl("mem0_after", 0, 0, 0, 0, 0);
    tick();

    // three-cycle memory wait with a deferred branch
    mem_req = 1'b1; br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 expect_ctl($sformatf("mwait%0d", i), 1, 1, 0, 0, 1);
      tick();
    end
    mem_ready = 1'b1;
    #1 expect_ctl("mwait_rdy", 0, 0, 1, 1, 0);
    tick();
    idle();
    #1 expect_ctl("mwait_run", 0, 0, 0, 0, 0);
    check("mwait.stall_cnt", 32'(ifa.stall_cnt), 32'(exp_sc));
    tick();

    // timeout on the TIMEOUT=4 instance
    rst = 1'b1; tick(); rst = 1'b0;
    mem_req = 1'b1; mem_ready = 1'b0;
    #1 check("to.run_freeze", 32'(ifb.pipe_freeze), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("to.mem_err%0d", i), 32'(ifb.mem_err), 32'(i == 5));
      check($sformatf("to.freeze%0d", i),  32'(ifb.pipe_freeze), 32'd1);
    end
    mem_req = 1'b0;
    #1 check("to.err_freeze", 32'(ifb.pipe_freeze), 32'd1);
    check("to.err_pc", 32'(ifb.pc_freeze), 32'd1);
    tick();
    // rst clears ERR (small) and WAIT (default instance)
    rst = 1'b1; tick(); rst = 1'b0; idle();
    #1 check("to.rst_err",   32'(ifb.mem_err),     32'd0);
    check("to.rst_freeze",   32'(ifb.pipe_freeze), 32'd0);
    check("wait.rst_freeze", 32'(ifa.pipe_freeze), 32'd0);
    check("wait.rst_cnt",    32'(ifa.stall_cnt),   32'd0);
    tick();

    // ready exactly at wait_cnt = TIMEOUT-1
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    mem_ready = 1'b1;
    #1 check("late.freeze", 32'(ifb.pipe_freeze), 32'd0);
    tick();
    idle();
    #1 check("late.mem_err", 32'(ifb.mem_err),     32'd0);
    check("late.run",        32'(ifb.pipe_freeze), 32'd0);
    tick();

    // saturation: 20 stall cycles
    rst = 1'b1; tick(); rst = 1'b0;
    exp_sc = 0;
    load_use(5'd5);
    for (int i = 0; i < 20; i++) begin
      #1 expect_ctl("sat", 1, 1, 0, 1, 0);
      tick();
      if (i == 14) check("sat.cnt15", 32'(ifb.stall_cnt), 32'd15);
    end
    idle();
    #1 check("sat.small_cnt", 32'(ifb.stall_cnt), 32'd15);
    check("sat.wide_cnt",     32'(ifa.stall_cnt), 32'(exp_sc));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline controller for the 5-stage MIPS core. It drives the freeze/flush/bubble controls of the PC register and the IF2ID and ID2EXE stage registers. It covers three cases: RAW hazards detected in ID, taken branches resolved in EXE, and multi-cycle data-memory accesses that stall the whole pipe. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles spent waiting for `mem_ready` before the error state is entered. Legal range 2..65535.
- `CNT_W`, default 16: width of `stall_cnt`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_src1`, `id_src2`  in  5 each  source register numbers of the instruction in ID.
- `id_two_src`  in  1  the ID instruction reads `id_src2`; otherwise only `id_src1` is compared.
- `exe_wb_en`, `exe_mem_read`  in  1 each  EXE instruction writes back / is a load.
- `exe_dest`  in  5  EXE destination register.
- `mem_wb_en`  in  1  MEM instruction writes back.
- `mem_dest`  in  5  MEM destination register.
- `br_taken`  in  1  EXE has resolved a taken branch or jump.
- `mem_req`  in  1  MEM stage holds a load or store.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_freeze`  out  1  hold the PC.
- `if2id_freeze`  out  1  freeze for IF2ID.
- `if2id_flush`  out  1  flush for IF2ID.
- `id2exe_bubble`  out  1  load a NOP into ID2EXE.
- `pipe_freeze`  out  1  hold ID2EXE, EXE2MEM and MEM2WB.
- `mem_err`  out  1  sticky memory-timeout flag.
- `stall_cnt`  out  `CNT_W`  count of cycles with `pc_freeze`=1.

## Operation
- The FSM has three states: RUN, WAIT, ERR.
  - RUN → WAIT when `mem_req`=1 and `mem_ready`=0.
  - WAIT → RUN when `mem_ready`=1.
  - WAIT → ERR when `wait_cnt` reaches `TIMEOUT-1` and `mem_ready`=0.
  - ERR is left only by `rst`.
- Memory stall:
  - `pipe_freeze` = (RUN & `mem_req` & ~`mem_ready`) | (WAIT & ~`mem_ready`) | ERR.
  - While `pipe_freeze`=1, `pc_freeze` and `if2id_freeze` are also 1, and `if2id_flush` and `id2exe_bubble` are 0.
  - Memory stall has the highest priority.
- Branch, when not in a memory stall: `br_taken`=1 forces `if2id_flush`=1 and `id2exe_bubble`=1 in the same cycle.
  - Branch overrides any data hazard: `pc_freeze` stays 0 so the target is fetched.
  - A branch held in a frozen EXE is serviced in the first unfrozen cycle.
- Data hazard, when there is no memory stall and no branch:
  - A match is: src == dest, dest != 0, and the corresponding wb_en = 1.
  - `id_src2` is only compared when `id_two_src`=1.
  - On a hazard, `pc_freeze`=1, `if2id_freeze`=1 and `id2exe_bubble`=1 for each cycle the condition holds.
  - Which matches count as a hazard depends on `FORWARD_EN` (see Configuration).
- `wait_cnt`:
  - Clears on entry to WAIT and increments each cycle in WAIT.
  - Width is `$clog2(TIMEOUT+1)`.
- `stall_cnt`:
  - Increments on every cycle with `pc_freeze`=1.
  - Saturates at all-ones; it does not wrap.
- In ERR, `mem_err`=1 and all freezes stay asserted until `rst`.

## Timing
- All hazard, flush and freeze outputs are combinational from the inputs and the current state, with zero-cycle latency. This is required because the stage registers sample them on the same edge.
- The FSM, `wait_cnt`, `stall_cnt` and `mem_err` are registered.
- Values while `rst`=1 and after reset:
  - State is RUN; `wait_cnt`, `stall_cnt` and `mem_err` are 0.
  - All combinational outputs are forced to 0 while `rst`=1.
- `mem_req` with `mem_ready`=1 in the same cycle in RUN is a zero-stall access and causes no state change.
- A single-wait access takes 1 cycle in RUN plus 1 cycle in WAIT, so `pipe_freeze` is high for exactly 1 cycle.
- With `TIMEOUT`=N and `mem_ready` never asserted:
  - `mem_err` rises on the edge ending the N-th cycle of WAIT.
  - `pipe_freeze` is high for N+1 cycles, then stays high in ERR.
- `mem_ready` arriving in the same cycle as `wait_cnt`=`TIMEOUT-1` returns to RUN; no error is raised.
- `rst` during WAIT or ERR returns to RUN on the next edge, with counters and `mem_err` cleared.

## Configuration
- `PIPE_FORWARD_EN` defined:
  - A forwarding unit exists, so only the load-use case is a hazard: a match against EXE with `exe_mem_read`=1.
  - Matches against MEM never stall.
- `PIPE_FORWARD_EN` undefined:
  - Any match against EXE (`exe_wb_en`) or MEM (`mem_wb_en`) is a hazard.
  - `exe_mem_read` is ignored.

## Test plan
- Reset: `rst`=1 for 2 cycles with `mem_req`=1 and `br_taken`=1 → all outputs 0, then `stall_cnt`=0 and `mem_err`=0 after release.
- Load-use: EXE has load `exe_dest`=5; ID has `id_src1`=5 → `pc_freeze`, `if2id_freeze` and `id2exe_bubble` are 1 for 1 cycle; `stall_cnt`=1.
  - Same stimulus with `exe_dest`=0 → no stall.
  - Without `PIPE_FORWARD_EN`, `mem_dest`=5 with `mem_wb_en`=1 also stalls.
- Branch and hazard together: `br_taken`=1 while the load-use condition holds → `if2id_flush`=1, `id2exe_bubble`=1, `pc_freeze`=0.
- Memory wait: `mem_req`=1 with `mem_ready` low for 3 cycles → `pipe_freeze` high for exactly 3 cycles, deasserting in the cycle `mem_ready`=1; state returns to RUN.
  - A concurrent `br_taken` is deferred: `if2id_flush` is 0 during the freeze and 1 in the next cycle.
- Timeout: `TIMEOUT`=4, `mem_ready` held 0 → `mem_err`=1 after 4 WAIT cycles, `pipe_freeze` stays 1.
  - `rst` then clears the error to RUN.
  - A variant with `mem_ready`=1 exactly at `wait_cnt`=3 gives no error.
- Saturation: `CNT_W`=4 with 20 consecutive stall cycles → `stall_cnt` holds 15.
